// File: rtl/cpart_burst_capture.sv
// cpart_burst_capture: samples serial data on clkMod pulses, frames words on the low gap,
// and presents good words over valid/ready while flagging framing errors and overruns.
module cpart_burst_capture #(
  parameter int PULSES  = 7,
  parameter int GAP_LEN = 3
) (
  input  logic              sysClk,
  input  logic              sysRst,
  input  logic              clkMod,
  input  logic              serDin,
  input  logic              frameReady,
  output logic [PULSES-1:0] dataOut,
  output logic              frameValid,
  output logic              frameErr,
  output logic              overrun
);
  localparam int CW = $clog2(PULSES + 2);
  localparam int LW = $clog2(GAP_LEN + 1);
  logic              prevMod;
  logic              synced;
  logic [LW-1:0]     lowRun;
  logic [CW-1:0]     pulseCnt;
  logic [PULSES-1:0] shift;
  logic              rise, gap, eval, good, load;
  always_comb begin
    rise = clkMod & ~prevMod;
    gap  = ~clkMod && (lowRun == LW'(GAP_LEN - 1));
    eval = gap & synced;
    good = eval && (pulseCnt == CW'(PULSES));
    load = good & (~frameValid | frameReady);
  end
  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      prevMod    <= 1'b0;
      synced     <= 1'b0;
      lowRun     <= '0;
      pulseCnt   <= '0;
      shift      <= '0;
      dataOut    <= '0;
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      prevMod  <= clkMod;
      frameErr <= eval & ~good;
      overrun  <= good & frameValid & ~frameReady;
      lowRun   <= clkMod ? '0 : (lowRun == LW'(GAP_LEN)) ? lowRun : lowRun + 1'b1;
      if (gap) begin
        pulseCnt <= '0;
        shift    <= '0;
        synced   <= 1'b1;
      end else if (rise) begin
        shift    <= {shift[PULSES-2:0], serDin};
        pulseCnt <= (pulseCnt == CW'(PULSES + 1)) ? pulseCnt : pulseCnt + 1'b1;
      end
      // a fresh word takes priority over retiring the held one
      if (load) begin
        dataOut    <= shift;
        frameValid <= 1'b1;
      end else if (frameValid && frameReady) begin
        frameValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cpart_burst_capture.sv
// tb_cpart_burst_capture: directed scenarios plus randomized frames against a queue-based model.
module tb_cpart_burst_capture;
  localparam int P = 7;
  localparam int G = 3;
  localparam logic [15:0] STD = 16'b1010101010101000;
  logic sysClk = 1'b0, sysRst = 1'b0, clkMod = 1'b0, serDin = 1'b0, frameReady = 1'b0;
  logic [P-1:0] dataOut;
  logic frameValid, frameErr, overrun;
  int vectors = 0, miscompares = 0;

  cpart_burst_capture #(.PULSES(P), .GAP_LEN(G)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .clkMod(clkMod), .serDin(serDin),
    .frameReady(frameReady), .dataOut(dataOut), .frameValid(frameValid),
    .frameErr(frameErr), .overrun(overrun)
  );

  always #5 sysClk = ~sysClk;

  // reference model: bits captured per frame in a queue, lows counted as a plain integer
  bit mPrev, synced;
  int lows;
  bit q[$];
  logic [P-1:0] eData;
  logic eValid, eErr, eOvr;

  task automatic modelReset();
    mPrev = 0; synced = 0; lows = 0; q.delete();
    eData = '0; eValid = 0; eErr = 0; eOvr = 0;
  endtask

  task automatic modelStep(input logic m, input logic d, input logic r);
    int w;
    bit loaded;
    loaded = 0; eErr = 0; eOvr = 0;
    lows = m ? 0 : lows + 1;
    if (m && !mPrev) q.push_back(d);
    if (!m && lows == G) begin
      if (synced) begin
        if (q.size() == P) begin
          w = 0;
          foreach (q[i]) w = w * 2 + int'(q[i]);
          if (!eValid || r) begin eData = P'(w); loaded = 1; end
          else eOvr = 1;
        end else eErr = 1;
      end
      q.delete();
      synced = 1;
    end
    if (loaded) eValid = 1;
    else if (eValid && r) eValid = 0;
    mPrev = m;
  endtask

  task automatic tick(input logic m, input logic d, input logic r);
    clkMod = m; serDin = d; frameReady = r;
    @(posedge sysClk);
    if (sysRst) modelStep(m, d, r);
    #1;
  endtask

  task automatic frame(input logic [15:0] pat, input logic [P-1:0] w, input logic rBody, input logic rGap);
    int k;
    logic m, d;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      m = pat[15-i];
      d = 1'b0;
      if (m && !clkMod) begin
        if (k < P) d = w[P-1-k];
        k++;
      end
      tick(m, d, i == 15 ? rGap : rBody);
    end
  endtask

  task automatic test_reset();
    modelReset();
    sysRst = 1'b0;
    tick(0, 0, 0); tick(1, 1, 1);
    vectors++; if (dataOut !== '0) begin miscompares++; $display("FAIL reset_data got %h want 00", dataOut); end
    vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", frameValid); end
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", frameErr); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr got %b want 0", overrun); end
    clkMod = 1'b0;
    sysRst = 1'b1;
  endtask

  task automatic test_basic();
    frame(STD, 7'h00, 1, 1);
    vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL sync_valid got %b want 0", frameValid); end
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL sync_err got %b want 0", frameErr); end
    frame(STD, 7'h55, 1, 1);
    vectors++; if (frameValid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", frameValid); end
    vectors++; if (dataOut !== 7'h55) begin miscompares++; $display("FAIL basic_data got %h want 55", dataOut); end
    tick(0, 0, 1);
    vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL basic_retire got %b want 0", frameValid); end
    vectors++; if (dataOut !== 7'h55) begin miscompares++; $display("FAIL basic_hold got %h want 55", dataOut); end
  endtask

  task automatic test_overrun();
    frame(STD, 7'h7F, 0, 0);
    vectors++; if (dataOut !== 7'h7F || frameValid !== 1'b1) begin miscompares++; $display("FAIL ovr_first got %h/%b want 7f/1", dataOut, frameValid); end
    frame(STD, 7'h01, 0, 0);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_pulse got %b want 1", overrun); end
    vectors++; if (dataOut !== 7'h7F || frameValid !== 1'b1) begin miscompares++; $display("FAIL ovr_keep got %h/%b want 7f/1", dataOut, frameValid); end
    tick(0, 0, 0);
    vectors++; if (overrun !== 1'b0 || frameValid !== 1'b1) begin miscompares++; $display("FAIL ovr_clear got %b/%b want 0/1", overrun, frameValid); end
    tick(0, 0, 1);
    vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL ovr_retire got %b want 0", frameValid); end
  endtask

  task automatic test_short();
    frame(16'b0010101010101000, 7'h3F, 0, 0);
    vectors++; if (frameErr !== 1'b1 || frameValid !== 1'b0) begin miscompares++; $display("FAIL short_err got %b/%b want 1/0", frameErr, frameValid); end
    tick(0, 0, 0);
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL short_once got %b want 0", frameErr); end
    frame(STD, 7'h2A, 0, 0);
    vectors++; if (dataOut !== 7'h2A || frameValid !== 1'b1 || frameErr !== 1'b0) begin miscompares++; $display("FAIL short_next got %h/%b/%b want 2a/1/0", dataOut, frameValid, frameErr); end
    tick(0, 0, 1);
  endtask

  task automatic test_back_to_back();
    frame(STD, 7'h13, 0, 0);
    vectors++; if (dataOut !== 7'h13 || frameValid !== 1'b1) begin miscompares++; $display("FAIL b2b_first got %h/%b want 13/1", dataOut, frameValid); end
    frame(STD, 7'h6C, 0, 1);
    vectors++; if (dataOut !== 7'h6C || frameValid !== 1'b1 || overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_second got %h/%b/%b want 6c/1/0", dataOut, frameValid, overrun); end
    tick(0, 0, 1);
    vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL b2b_retire got %b want 0", frameValid); end
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 10; i++) tick(1, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(0, 0, 0);
      vectors++; if (frameErr !== (i == 3) || frameValid !== 1'b0) begin miscompares++; $display("FAIL stuck_low%0d got err=%b valid=%b want err=%b valid=0", i, frameErr, frameValid, i == 3); end
    end
  endtask

  task automatic test_async_reset();
    frame(STD, 7'h5A, 0, 0);
    vectors++; if (frameValid !== 1'b1) begin miscompares++; $display("FAIL arst_pre got %b want 1", frameValid); end
    #3 sysRst = 1'b0;
    #1;
    vectors++; if (dataOut !== '0 || frameValid !== 1'b0 || frameErr !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL arst_clear got %h/%b/%b/%b want 00/0/0/0", dataOut, frameValid, frameErr, overrun); end
    modelReset();
    tick(0, 0, 0);
    sysRst = 1'b1;
    frame(STD, 7'h33, 1, 1);
    vectors++; if (frameValid !== 1'b0 || frameErr !== 1'b0) begin miscompares++; $display("FAIL arst_resync got %b/%b want 0/0", frameValid, frameErr); end
    frame(STD, 7'h33, 0, 0);
    vectors++; if (dataOut !== 7'h33 || frameValid !== 1'b1) begin miscompares++; $display("FAIL arst_after got %h/%b want 33/1", dataOut, frameValid); end
    tick(0, 0, 1);
  endtask

  task automatic test_random();
    logic [15:0] pat;
    logic [P-1:0] w;
    logic m, d;
    int k;
    for (int f = 0; f < 80; f++) begin
      pat = STD;
      if ($urandom_range(0, 3) == 0) pat[$urandom_range(0, 15)] = ~pat[$urandom_range(0, 15)];
      w = P'($urandom);
      k = 0;
      for (int i = 0; i < 16; i++) begin
        m = pat[15-i];
        d = 1'($urandom);
        if (m && !clkMod) begin
          if (k < P) d = w[P-1-k];
          k++;
        end
        tick(m, d, 1'($urandom_range(0, 1)));
        vectors++;
        if (dataOut !== eData || frameValid !== eValid || frameErr !== eErr || overrun !== eOvr || (frameErr && overrun)) begin
          miscompares++;
          $display("FAIL rand f%0d c%0d got %h/%b/%b/%b want %h/%b/%b/%b", f, i, dataOut, frameValid, frameErr, overrun, eData, eValid, eErr, eOvr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_short();
    test_back_to_back();
    test_stuck();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpart_burst_capture.md
Name: cpart_burst_capture

Overview:
- Downstream consumer of the C-part clock generator's `clkMod`.
- Each 16-cycle frame carries 7 `clkMod` pulses, then a 3-cycle low gap. The block samples a serial data line on each pulse and assembles the bits into a word.
- It detects the frame gap and checks the pulse count. It presents each good word on a valid/ready interface, or flags a framing error.
- Everything runs in the `sysClk` domain, with `clkMod` treated as a synchronous level.

Parameters:
- PULSES, 7, expected pulses per frame; also the word width.
- GAP_LEN, 3, consecutive low samples of `clkMod` that mark the end of a frame (must be ≥2).

Ports:
- sysClk, input, 1: system clock; all state changes on the rising edge.
- sysRst, input, 1: asynchronous, active-low reset.
- clkMod, input, 1: burst pulse train from the clock generator, sampled each `sysClk` edge.
- serDin, input, 1: serial data, valid in any cycle where `clkMod` is high.
- frameReady, input, 1: consumer accepts the held word.
- dataOut, output, PULSES: assembled word; the first-captured bit lands in the MSB.
- frameValid, output, 1: `dataOut` holds an unconsumed good frame.
- frameErr, output, 1: one-cycle pulse on a bad frame.
- overrun, output, 1: one-cycle pulse when a good frame is dropped.

Behaviour:
- Reset (`sysRst`=0, asynchronous):
  - Outputs: `dataOut`=0, `frameValid`=0, `frameErr`=0, `overrun`=0.
  - Internal state: prevMod=0, lowRun=0, pulseCnt=0, shift=0, synced=0.
- Pulse detect: rise = `clkMod` & ~prevMod. prevMod <= `clkMod` every cycle.
- On rise:
  - shift <= {shift[PULSES-2:0], `serDin`}.
  - pulseCnt <= pulseCnt+1, saturating at PULSES+1.
  - lowRun <= 0.
- `clkMod` high without a rise (stuck high): lowRun <= 0, nothing else changes.
- `clkMod` low: lowRun <= lowRun+1, saturating at GAP_LEN.
- Gap event: `clkMod`=0 and lowRun==GAP_LEN-1 (the GAP_LEN-th consecutive low sample). It fires once per gap; a longer idle does not refire.
- On a gap event:
  - pulseCnt <= 0 and shift <= 0.
  - synced <= 1.
  - The frame is evaluated only if synced was already 1.
- The first gap after reset only establishes sync. The partial frame before it is discarded silently: no `frameErr`, no `frameValid`.
- Evaluation, when synced=1 at the gap event:
  - pulseCnt==PULSES, completed-word path:
    - If `frameValid`=0, or (`frameValid`=1 and `frameReady`=1): `dataOut` <= shift, `frameValid` <= 1.
    - If `frameValid`=1 and `frameReady`=0: `dataOut` keeps its old word, `overrun` <= 1 for one cycle.
  - pulseCnt≠PULSES, including 0 and saturated values: `frameErr` <= 1 for one cycle; `dataOut`/`frameValid` unchanged, apart from normal handshake retirement.
- Handshake:
  - `frameValid` & `frameReady` with no completed word in the same cycle: `frameValid` <= 0.
  - `dataOut` holds its value after consumption until the next good frame.
- Latency: outputs are registered. `frameValid`/`frameErr`/`overrun` become visible the cycle after the GAP_LEN-th low sample. With the standard generator, that is the cycle in which the counter reads 0 again.
- `frameErr` and `overrun` are never both 1.
- `frameReady` is ignored while `frameValid`=0.
- Reset mid-frame: everything clears immediately, and sync must be re-acquired.

Test Plan:
- Reset, then drive the standard 16-cycle `clkMod` pattern (1010101010101000) with idle `serDin` → first gap: no `frameValid`/`frameErr`. Second frame with `serDin`=1,0,1,0,1,0,1 on the pulses and `frameReady`=1 → `dataOut`=7'h55, `frameValid`=1 for exactly one cycle, one cycle after the third low sample.
- Two consecutive frames, 7'h7F then 7'h01, with `frameReady`=0 → `dataOut`=7'h7F, `frameValid` held, `overrun`=1 one cycle at the second gap, `dataOut` still 7'h7F. Raise `frameReady` → `frameValid` drops the next cycle.
- Frame with only 6 pulses (one pulse suppressed) after sync → `frameErr`=1 for one cycle, `frameValid` stays 0. The next normal frame is captured correctly.
- `frameValid`=1 with `frameReady`=1 in the same cycle as a new good frame's gap event → new word loaded, `frameValid` stays 1, `overrun`=0.
- `clkMod` held high for 10 cycles then low for 5 after sync → counted as one pulse; gap gives `frameErr`=1 exactly once, with no refire during cycles 4-5 of the low run.
- Assert `sysRst`=0 asynchronously mid-frame while `frameValid`=1 → all outputs 0 immediately, without waiting for a clock edge. After release, the first gap produces no output.
